wash_duration_timer: RTL and testbench



---
 rtl/washer_pkg.sv | 38 +++
 rtl/wash_tick_gen.sv | 39 +++
 rtl/wash_duration_timer.sv | 125 ++++++++++++
 tb/tb_wash_duration_timer.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/washer_pkg.sv
// Shared washer definitions: phase codes driven by the washer FSM, duration
// timer state encoding, default phase durations and the duration clamp helper.
package washer_pkg;

   localparam logic [2:0] PHASE_IDLE  = 3'b000;
   localparam logic [2:0] PHASE_FILL  = 3'b001;
   localparam logic [2:0] PHASE_WASH  = 3'b010;
   localparam logic [2:0] PHASE_RINSE = 3'b011;
   localparam logic [2:0] PHASE_SPIN  = 3'b100;
   localparam logic [2:0] PHASE_DONE  = 3'b101;

   localparam int TICKS_PER_MIN_DEF = 60;
   localparam int FILL_MIN_DEF      = 1;
   localparam int WASH_MIN_DEF      = 5;
   localparam int RINSE_MIN_DEF     = 2;
   localparam int SPIN_MIN_DEF      = 1;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RUN     = 2'd1,
      ST_PAUSED  = 2'd2,
      ST_EXPIRED = 2'd3
   } timer_state_t;

   // Durations live in a 4-bit minute counter; zero would never expire.
   function automatic logic [3:0] clamp_min(input int minutes);
      logic [3:0] res;
      if (minutes < 1) begin
         res = 4'd1;
      end else if (minutes > 15) begin
         res = 4'd15;
      end else begin
         res = 4'(minutes);
      end
      return res;
   endfunction

endpackage

// File: rtl/wash_tick_gen.sv
// Minute prescaler: counts 0..TICKS_PER_MIN-1 while enabled; wrap_o flags the
// terminal count so the owner can qualify it with its own enable.
module wash_tick_gen
   import washer_pkg::*;
#(
   parameter int TICKS_PER_MIN = TICKS_PER_MIN_DEF
) (
   input  logic Trigger_clk_FSM,
   input  logic Rst_n,
   input  logic enable_i,
   input  logic clear_i,
   output logic wrap_o
);

   localparam int CW = $clog2(TICKS_PER_MIN);
   localparam logic [CW-1:0] LAST = CW'(TICKS_PER_MIN - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   assign wrap_o = (cnt_q == LAST);

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (enable_i) begin
         cnt_d = wrap_o ? '0 : cnt_q + CW'(1);
      end
   end

   always_ff @(posedge Trigger_clk_FSM or negedge Rst_n) begin
      if (!Rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/wash_duration_timer.sv
// Washer phase duration timer: decodes the phase code, counts minutes and
// pulses Expire. Lid-open pause in spin is built only with WASH_TIMER_PAUSE_EN.
//
// state      | meaning
// ST_IDLE    | untimed code (idle/done/illegal), nothing counting
// ST_RUN     | prescaler running, minute counter live
// ST_PAUSED  | spin frozen by lid-open pause
// ST_EXPIRED | phase elapsed, waiting for the next code change
module wash_duration_timer
   import washer_pkg::*;
#(
   parameter int TICKS_PER_MIN = TICKS_PER_MIN_DEF,
   parameter int FILL_MIN      = FILL_MIN_DEF,
   parameter int WASH_MIN      = WASH_MIN_DEF,
   parameter int RINSE_MIN     = RINSE_MIN_DEF,
   parameter int SPIN_MIN      = SPIN_MIN_DEF
) (
   input  logic       Trigger_clk_FSM,
   input  logic       Rst_n,
   input  logic [2:0] Duration_code,
   input  logic       Pause,
   output logic       Expire,
   output logic [3:0] Remaining_min,
   output logic       Busy
);

`ifdef WASH_TIMER_PAUSE_EN
   localparam bit PAUSE_EN = 1'b1;
`else
   localparam bit PAUSE_EN = 1'b0;
`endif

   localparam logic [3:0] FILL_D  = clamp_min(FILL_MIN);
   localparam logic [3:0] WASH_D  = clamp_min(WASH_MIN);
   localparam logic [3:0] RINSE_D = clamp_min(RINSE_MIN);
   localparam logic [3:0] SPIN_D  = clamp_min(SPIN_MIN);

   timer_state_t state_q, state_d;
   logic [2:0]   code_q;
   logic [3:0]   rem_q, rem_d;
   logic         expire_q, expire_d;
   logic         tick_en, tick_clr, wrap;
   logic         change, timed, pause_act;
   logic [3:0]   load_val;

   assign change    = (Duration_code != code_q);
   assign pause_act = PAUSE_EN && Pause && (code_q == PHASE_SPIN);

   always_comb begin
      timed    = 1'b1;
      load_val = 4'd0;
      case (Duration_code)
         PHASE_FILL:  load_val = FILL_D;
         PHASE_WASH:  load_val = WASH_D;
         PHASE_RINSE: load_val = RINSE_D;
         PHASE_SPIN:  load_val = SPIN_D;
         default:     timed    = 1'b0;
      endcase
   end

   wash_tick_gen #(.TICKS_PER_MIN(TICKS_PER_MIN)) u_tick (
      .Trigger_clk_FSM (Trigger_clk_FSM),
      .Rst_n           (Rst_n),
      .enable_i        (tick_en),
      .clear_i         (tick_clr),
      .wrap_o          (wrap)
   );

   always_comb begin
      state_d  = state_q;
      rem_d    = rem_q;
      expire_d = 1'b0;
      tick_en  = 1'b0;
      tick_clr = 1'b0;
      if (change) begin
         tick_clr = 1'b1;
         if (timed) begin
            rem_d   = load_val;
            state_d = ST_RUN;
         end else begin
            rem_d   = 4'd0;
            state_d = ST_IDLE;
         end
      end else begin
         case (state_q)
            ST_RUN, ST_PAUSED: begin
               // Pause outranks expiry: a paused edge never advances the count.
               if (pause_act) begin
                  state_d = ST_PAUSED;
               end else begin
                  state_d = ST_RUN;
                  tick_en = 1'b1;
                  if (wrap && (rem_q != 4'd0)) begin
                     rem_d = rem_q - 4'd1;
                     if (rem_q == 4'd1) begin
                        expire_d = 1'b1;
                        state_d  = ST_EXPIRED;
                     end
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge Trigger_clk_FSM or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q  <= ST_IDLE;
         code_q   <= PHASE_IDLE;
         rem_q    <= 4'd0;
         expire_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         code_q   <= Duration_code;
         rem_q    <= rem_d;
         expire_q <= expire_d;
      end
   end

   assign Expire        = expire_q;
   assign Remaining_min = rem_q;
   assign Busy          = (state_q == ST_RUN) || (state_q == ST_PAUSED);

endmodule

// File: tb/tb_wash_duration_timer.sv
// Bench for wash_duration_timer with TICKS_PER_MIN=4: expected expiry cycles
// are queued by the stimulus and matched by a monitor on every Expire pulse.
module tb_wash_duration_timer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [2:0] code = 3'b000;
   logic       pause = 1'b0;
   logic       expire;
   logic [3:0] rem;
   logic       busy;

   int cyc = 0;
   int n_tests = 0;
   int n_fail = 0;
   int exp_q[$];
   int mon_e;

   wash_duration_timer #(.TICKS_PER_MIN(4)) dut (
      .Trigger_clk_FSM (clk),
      .Rst_n           (rst_n),
      .Duration_code   (code),
      .Pause           (pause),
      .Expire          (expire),
      .Remaining_min   (rem),
      .Busy            (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int req);
      n_tests++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Monitor: every Expire pulse must match the oldest queued expiry cycle.
   always @(negedge clk) begin
      if (rst_n && expire) begin
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_expire: pulse at cycle %0d, none expected", cyc);
         end else begin
            mon_e = exp_q.pop_front();
            check("expire_cycle", cyc, mon_e);
         end
      end
   end

   task automatic wait_cyc(input int t);
      while (cyc < t) @(negedge clk);
   endtask

   task automatic go_idle();
      @(negedge clk);
      code = 3'b000;
      pause = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   initial begin
      #200000;
      n_tests++;
      n_fail++;
      $display("FAIL timeout: simulation did not complete");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      int L;
      int L2;
      int steps[8];
      steps = '{0, 3, 4, 8, 12, 16, 19, 20};

      // Reset values
      repeat (3) @(negedge clk);
      check("rst_expire", int'(expire), 0);
      check("rst_rem", int'(rem), 0);
      check("rst_busy", int'(busy), 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Fill: one minute
      code = 3'b001;
      L = cyc + 1;
      exp_q.push_back(L + 4);
      wait_cyc(L);
      check("fill_rem_load", int'(rem), 1);
      check("fill_busy", int'(busy), 1);
      wait_cyc(L + 4);
      check("fill_busy_drop", int'(busy), 0);
      check("fill_rem_end", int'(rem), 0);
      wait_cyc(L + 24);
      go_idle();

      // Wash: five minutes, minute counter steps
      code = 3'b010;
      L = cyc + 1;
      exp_q.push_back(L + 20);
      foreach (steps[i]) begin
         wait_cyc(L + steps[i]);
         check("wash_rem_step", int'(rem), 5 - steps[i] / 4);
      end
      wait_cyc(L + 22);
      go_idle();

      // Spin with lid-open pause over edges 2..8
      code = 3'b100;
      L = cyc + 1;
`ifdef WASH_TIMER_PAUSE_EN
      exp_q.push_back(L + 11);
`else
      exp_q.push_back(L + 4);
`endif
      wait_cyc(L + 1);
      pause = 1'b1;
      wait_cyc(L + 5);
`ifdef WASH_TIMER_PAUSE_EN
      check("spin_paused_busy", int'(busy), 1);
      check("spin_paused_rem", int'(rem), 1);
`else
      check("spin_nopause_busy", int'(busy), 0);
      check("spin_nopause_rem", int'(rem), 0);
`endif
      wait_cyc(L + 8);
      pause = 1'b0;
      wait_cyc(L + 14);
      go_idle();

      // Rinse expires, then double wash reloads
      code = 3'b011;
      L = cyc + 1;
      exp_q.push_back(L + 8);
      wait_cyc(L + 10);
      check("rinse_expired_busy", int'(busy), 0);
      check("rinse_expired_rem", int'(rem), 0);
      code = 3'b010;
      L2 = cyc + 1;
      exp_q.push_back(L2 + 20);
      wait_cyc(L2);
      check("rewash_rem_load", int'(rem), 5);
      wait_cyc(L2 + 22);
      go_idle();

      // Code change exactly on the wash expiry edge
      code = 3'b010;
      L = cyc + 1;
      wait_cyc(L + 19);
      code = 3'b011;
      exp_q.push_back(L + 28);
      wait_cyc(L + 20);
      check("collide_rem", int'(rem), 2);
      check("collide_busy", int'(busy), 1);
      wait_cyc(L + 30);
      go_idle();

      // Reset mid-wash, timing restarts in full with code still driven
      code = 3'b010;
      L = cyc + 1;
      wait_cyc(L + 8);
      rst_n = 1'b0;
      #1;
      check("midrst_rem", int'(rem), 0);
      check("midrst_busy", int'(busy), 0);
      check("midrst_expire", int'(expire), 0);
      @(negedge clk);
      rst_n = 1'b1;
      L2 = cyc + 1;
      exp_q.push_back(L2 + 20);
      wait_cyc(L2);
      check("postrst_rem", int'(rem), 5);
      check("postrst_busy", int'(busy), 1);
      wait_cyc(L2 + 22);

      // Illegal codes abort a running phase and never expire
      code = 3'b001;
      repeat (2) @(negedge clk);
      code = 3'b110;
      @(negedge clk);
      check("code110_busy", int'(busy), 0);
      check("code110_rem", int'(rem), 0);
      code = 3'b111;
      @(negedge clk);
      check("code111_busy", int'(busy), 0);
      check("code111_rem", int'(rem), 0);
      repeat (20) @(negedge clk);

      check("scoreboard_empty", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
